// File: rtl/mod_mul_pkg.sv
// rtl/mod_mul_pkg.sv - shared constants and result-entry type for the modular multiplier scheduler
package mod_mul_pkg;

  localparam int Q_LEN_DEF      = 64;
  localparam int R_DEF          = 32;
  localparam int MUL_LAT_DEF    = 9;
  localparam int N_REQ_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int ID_W_DEF       = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [Q_LEN_DEF-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - synchronous first-word-fall-through FIFO with occupancy outputs
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_fire = rd_en && !empty;
  // Head is zero while empty so downstream sees a clean bus.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_fire);
    count_d  = count_q + CW'(wr_en) - CW'(rd_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mod_mul_sched.sv
// rtl/mod_mul_sched.sv - round-robin scheduler sharing one pipelined modular multiplier
module mod_mul_sched
  import mod_mul_pkg::*;
#(
  parameter int Q_LEN      = Q_LEN_DEF,
  parameter int R          = R_DEF,
  parameter int N_REQ      = N_REQ_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*Q_LEN-1:0] req_a,
  input  logic [N_REQ*Q_LEN-1:0] req_b,
  input  logic                   cfg_qh_we,
  input  logic [Q_LEN-R-1:0]     cfg_qh,
  output logic                   cfg_busy,
  output logic                   mul_vld,
  output logic [Q_LEN-1:0]       mul_a,
  output logic [Q_LEN-1:0]       mul_b,
  output logic [Q_LEN-R-1:0]     mul_qh,
  input  logic [Q_LEN-1:0]       mul_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [Q_LEN-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   idle
);

  localparam int QH_W  = Q_LEN - R;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int E_W   = ID_W + Q_LEN;

  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic                          mul_vld_q, mul_vld_d;
  logic [Q_LEN-1:0]              mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [ID_W-1:0]               mul_id_q, mul_id_d;
  logic [QH_W-1:0]               mul_qh_q, mul_qh_d;
  logic [QH_W-1:0]               cfg_pend_q, cfg_pend_d;
  logic                          cfg_busy_q, cfg_busy_d;
  logic [CNT_W-1:0]              credit_q, credit_d;
  logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             found, en, accept, rsp_hs, drain_ok;
  int               idx;

  logic             fifo_wr, fifo_full, fifo_empty;
  logic [E_W-1:0]   fifo_rd;
  logic [CNT_W-1:0] fifo_count;

  assign en        = !rst && (credit_q < CNT_W'(FIFO_DEPTH)) && !cfg_busy_q;
  assign req_ready = en ? grant : '0;
  assign accept    = en && found;
  assign rsp_valid = !fifo_empty;
  assign rsp_hs    = rsp_valid && rsp_ready;
  assign fifo_wr   = tag_vld_q[MUL_LAT-1];
  // The tag leaving this cycle is the last one in flight when nothing earlier is valid.
  assign drain_ok  = !mul_vld_q && (tag_vld_q[MUL_LAT-2:0] == '0);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    mul_vld_d = accept;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_id_d  = mul_id_q;
    if (accept) begin
      ptr_d    = grant_id;
      mul_a_d  = req_a[int'(grant_id)*Q_LEN +: Q_LEN];
      mul_b_d  = req_b[int'(grant_id)*Q_LEN +: Q_LEN];
      mul_id_d = grant_id;
    end
    tag_vld_d = {tag_vld_q[MUL_LAT-2:0], mul_vld_q};
    tag_id_d  = {tag_id_q[MUL_LAT-2:0], mul_id_q};

    credit_d = credit_q;
    if (accept && !rsp_hs)      credit_d = credit_q + CNT_W'(1);
    else if (!accept && rsp_hs) credit_d = credit_q - CNT_W'(1);

    cfg_pend_d = cfg_qh_we ? cfg_qh : cfg_pend_q;
    mul_qh_d   = mul_qh_q;
    cfg_busy_d = cfg_busy_q;
    if (cfg_busy_q && drain_ok) begin
      mul_qh_d   = cfg_pend_q;
      cfg_busy_d = 1'b0;
    end
    if (cfg_qh_we) cfg_busy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= ID_W'(N_REQ - 1);
      mul_vld_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_id_q   <= '0;
      mul_qh_q   <= '0;
      cfg_pend_q <= '0;
      cfg_busy_q <= 1'b0;
      credit_q   <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      mul_vld_q  <= mul_vld_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_id_q   <= mul_id_d;
      mul_qh_q   <= mul_qh_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_busy_q <= cfg_busy_d;
      credit_q   <= credit_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data ({tag_id_q[MUL_LAT-1], mul_c}),
    .rd_en   (rsp_ready),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rsp_id   = fifo_rd[E_W-1 -: ID_W];
  assign rsp_data = fifo_rd[Q_LEN-1:0];
  assign mul_vld  = mul_vld_q;
  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_qh   = mul_qh_q;
  assign cfg_busy = cfg_busy_q;
  assign idle     = (credit_q == '0) && !cfg_busy_q;

  // Credit accounting guarantees the FIFO never sees a write it cannot absorb.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && fifo_full && !rsp_hs));
  a_credit_cover : assert property (@(posedge clk) disable iff (rst)
    fifo_count <= credit_q);

endmodule

// File: tb/tb_mod_mul_sched.sv
// tb/tb_mod_mul_sched.sv - scoreboard bench for mod_mul_sched with directed vectors
module tb_mod_mul_sched;
  import mod_mul_pkg::*;

  localparam int Q_LEN      = 64;
  localparam int R          = 32;
  localparam int N_REQ      = 4;
  localparam int MUL_LAT    = 9;
  localparam int FIFO_DEPTH = 16;
  localparam int ID_W       = 2;
  localparam int QH_W       = Q_LEN - R;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*Q_LEN-1:0] req_a;
  logic [N_REQ*Q_LEN-1:0] req_b;
  logic                   cfg_qh_we;
  logic [QH_W-1:0]        cfg_qh;
  logic                   cfg_busy;
  logic                   mul_vld;
  logic [Q_LEN-1:0]       mul_a;
  logic [Q_LEN-1:0]       mul_b;
  logic [QH_W-1:0]        mul_qh;
  logic [Q_LEN-1:0]       mul_c;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [Q_LEN-1:0]       rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   idle;

  int n_pass  = 0;
  int n_total = 0;
  int n_rsp   = 0;

  rsp_entry_t exp_q[$];
  rsp_entry_t push_e, pop_e;
  logic [Q_LEN-1:0] stub_q [MUL_LAT];

  mod_mul_sched #(
    .Q_LEN(Q_LEN), .R(R), .N_REQ(N_REQ), .MUL_LAT(MUL_LAT),
    .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .cfg_qh_we(cfg_qh_we), .cfg_qh(cfg_qh), .cfg_busy(cfg_busy),
    .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_qh(mul_qh), .mul_c(mul_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: sum of operands, delayed MUL_LAT cycles, never reset.
  always @(posedge clk) begin
    stub_q[0] <= mul_a + mul_b;
    for (int i = 1; i < MUL_LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign mul_c = stub_q[MUL_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          push_e.id   = ID_W'(i);
          push_e.data = req_a[i*Q_LEN +: Q_LEN] + req_b[i*Q_LEN +: Q_LEN];
          exp_q.push_back(push_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got id %0d data 0x%0h expected no response at %0t", rsp_id, rsp_data, $time);
      end else begin
        pop_e = exp_q.pop_front();
        check("sb_id", 64'(rsp_id), 64'(pop_e.id));
        check("sb_data", rsp_data, pop_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (idle) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int first, n_acc, rsp0, changes;
  logic [QH_W-1:0] prev_qh;
  bit seen;

  initial begin
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
    cfg_qh_we = 1'b0; cfg_qh = '0; rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mul_vld", 64'(mul_vld), 64'd0);
    check("rst_mul_ab", 64'(mul_a | mul_b), 64'd0);
    check("rst_mul_qh", 64'(mul_qh), 64'd0);
    check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_bus", rsp_data | 64'(rsp_id), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    tick();
    req_valid = '0;
    rst = 1'b0;

    // Single op from requester 2
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[2*Q_LEN +: Q_LEN] = 64'd5;
    req_b[2*Q_LEN +: Q_LEN] = 64'd7;
    @(negedge clk);
    check("single_grant", 64'(req_ready), 64'b0100);
    first = -1;
    for (int k = 1; k < 20 && first < 0; k++) begin
      tick();
      req_valid = '0;
      @(negedge clk);
      if (k == 1) begin
        check("single_mul_vld", 64'(mul_vld), 64'd1);
        check("single_mul_a", mul_a, 64'd5);
        check("single_mul_b", mul_b, 64'd7);
        check("single_not_idle", 64'(idle), 64'd0);
      end
      if (rsp_valid) begin
        first = k;
        check("single_rsp_data", rsp_data, 64'd12);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
      end
    end
    check("single_latency", 64'(first), 64'd11);
    tick();
    @(negedge clk);
    check("single_idle_after", 64'(idle), 64'd1);

    // Round robin with all requesters valid after reset
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req_valid = '1;
      for (int i = 0; i < N_REQ; i++) begin
        req_a[i*Q_LEN +: Q_LEN] = 64'(k*4 + i + 1);
        req_b[i*Q_LEN +: Q_LEN] = 64'(i*1000);
      end
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    seen = 1'b0;
    for (int w = 0; w < 30 && !seen; w++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rr_rsp_seen", 64'(seen), 64'd1);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      check("rr_no_gap", 64'(rsp_valid), 64'd1);
      check("rr_rsp_id", 64'(rsp_id), 64'(j % 4));
    end
    wait_idle("rr_idle");

    // Credit exhaustion with a stalled consumer; operands wrap modulo 2^64
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    n_acc = 0;
    for (int k = 0; k < 30; k++) begin
      req_a[1*Q_LEN +: Q_LEN] = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(k);
      req_b[1*Q_LEN +: Q_LEN] = 64'h20;
      @(negedge clk);
      if (req_ready[1]) n_acc++;
      tick();
    end
    check("credit_accepts", 64'(n_acc), 64'd16);
    @(negedge clk);
    check("credit_block", 64'(req_ready), 64'd0);
    rsp0 = n_rsp;
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("credit_hs_cycle", 64'(req_ready), 64'd0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("credit_reaccept", 64'(req_ready), 64'b0010);
    tick();
    @(negedge clk);
    check("credit_refull", 64'(req_ready), 64'd0);
    check("credit_one_rsp", 64'(n_rsp - rsp0), 64'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle("credit_idle");

    // qH update waits for the in-flight ops to leave the tag pipe
    tick();
    for (int k = 0; k < 14; k++) begin
      req_valid = 4'b1000;
      req_a[3*Q_LEN +: Q_LEN] = 64'(20 + k);
      req_b[3*Q_LEN +: Q_LEN] = 64'd1;
      cfg_qh_we = (k == 2);
      cfg_qh = 32'h1234;
      @(negedge clk);
      if (k <= 2) check("cfg_pre_grant", 64'(req_ready), 64'b1000);
      if (k >= 3 && k <= 12) begin
        check("cfg_hold", 64'(req_ready), 64'd0);
        check("cfg_busy_hold", 64'(cfg_busy), 64'd1);
      end
      if (k == 3) begin
        check("cfg_third_issue", 64'(mul_vld), 64'd1);
        check("cfg_third_old_qh", 64'(mul_qh), 64'd0);
      end
      if (k == 12) check("cfg_qh_before", 64'(mul_qh), 64'd0);
      if (k == 13) begin
        check("cfg_new_qh", 64'(mul_qh), 64'h1234);
        check("cfg_busy_clear", 64'(cfg_busy), 64'd0);
        check("cfg_resume", 64'(req_ready), 64'b1000);
      end
      tick();
    end
    req_valid = '0;
    cfg_qh_we = 1'b0;
    wait_idle("cfg_idle");

    // Two writes while busy: last value wins, single update
    tick();
    changes = 0;
    prev_qh = '0;
    seen = 1'b0;
    req_a[0 +: Q_LEN] = 64'd1;
    req_b[0 +: Q_LEN] = 64'd2;
    for (int k = 0; k < 40 && !seen; k++) begin
      req_valid = (k == 0) ? 4'b0001 : 4'b0000;
      cfg_qh_we = (k == 1 || k == 2);
      cfg_qh = (k == 1) ? 32'hA : 32'hB;
      @(negedge clk);
      if (k == 0) prev_qh = mul_qh;
      else if (mul_qh != prev_qh) begin
        changes++;
        prev_qh = mul_qh;
      end
      if (k > 3 && idle) seen = 1'b1;
      tick();
    end
    cfg_qh_we = 1'b0;
    check("cfg2_done", 64'(seen), 64'd1);
    check("cfg2_updates", 64'(changes), 64'd1);
    check("cfg2_final_qh", 64'(mul_qh), 64'hB);

    // Asynchronous reset in the middle of a burst
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      req_valid = '1;
      for (int i = 0; i < N_REQ; i++) begin
        req_a[i*Q_LEN +: Q_LEN] = 64'(k*10 + i);
        req_b[i*Q_LEN +: Q_LEN] = 64'd7;
      end
      @(negedge clk);
      if (|req_ready) n_acc++;
      tick();
    end
    check("burst_accepts", 64'(n_acc), 64'd5);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_mul_vld", 64'(mul_vld), 64'd0);
    check("arst_mul_ab", 64'(mul_a | mul_b), 64'd0);
    check("arst_mul_qh", 64'(mul_qh), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check("arst_first_grant", 64'(req_ready), 64'b0001);
    rsp0 = n_rsp;
    tick();
    req_valid = '0;
    for (int w = 0; w < 25; w++) @(negedge clk);
    check("arst_rsp_count", 64'(n_rsp - rsp0), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mod_mul_sched.md
Name: mod_mul_sched

Overview:
Round-robin scheduler that shares one fully pipelined modular multiplier (Q_LEN-bit A*B mod q, fixed latency MUL_LAT) among N_REQ requesters. It issues at most one operation per cycle and tracks requester IDs through a tag pipeline aligned with the datapath. Results are buffered in a credit-protected output FIFO. It also owns the qH modulus configuration register and updates it only when the pipeline is drained.

Parameters:
Q_LEN, 64, operand/result width
R, 32, reduction split; qH width is Q_LEN-R
N_REQ, 4, number of requesters (>=2)
MUL_LAT, 9, cycles from mul_vld issue to matching mul_c; must equal the instantiated multiplier latency
FIFO_DEPTH, 16, result FIFO entries and total credit (power of 2)
ID_W, $clog2(N_REQ), requester ID width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  N_REQ*Q_LEN  operand A, requester i in slice i
req_b  in  N_REQ*Q_LEN  operand B, requester i in slice i
cfg_qh_we  in  1  qH write strobe
cfg_qh  in  Q_LEN-R  new qH
cfg_busy  out  1  qH update pending
mul_vld  out  1  issue strobe (registered)
mul_a  out  Q_LEN  operand A to multiplier (registered)
mul_b  out  Q_LEN  operand B to multiplier (registered)
mul_qh  out  Q_LEN-R  active qH (registered)
mul_c  in  Q_LEN  multiplier result
rsp_valid  out  1  FIFO non-empty
rsp_ready  in  1  consumer accept
rsp_data  out  Q_LEN  result at FIFO head
rsp_id  out  ID_W  requester ID of rsp_data
idle  out  1  no credits in use and no cfg pending

Behaviour:
- Reset values: req_ready=0, mul_vld=0, mul_a/mul_b=0, mul_qh=0, cfg_busy=0, rsp_valid=0, rsp_data/rsp_id=0, idle=1. RR pointer = N_REQ-1, so requester 0 has top priority. Tag pipeline, FIFO and counters are cleared.
- Reset mid-operation: all in-flight ops, FIFO contents and pending cfg are discarded. Late mul_c values are ignored because the tag valids are cleared.
- Issue enable (en): credit_cnt < FIFO_DEPTH and !cfg_busy.
- Arbitration: if en, grant the first asserted req_valid searching from ptr+1 with wrap. req_ready = grant, combinational from req_valid, with no dependence on req_ready. On a handshake, ptr <= granted index.
- Accept at cycle t: mul_vld/mul_a/mul_b registered at t+1. A tag {1,id} enters a MUL_LAT-deep shift register at t+1, so the tag exits at t+1+MUL_LAT together with mul_c. That cycle the FIFO writes {id, mul_c}. Total accept-to-rsp_valid latency is MUL_LAT+2 when the FIFO is empty.
- No accept: mul_vld=0 and mul_a/mul_b hold. A zero-valid tag is shifted in.
- credit_cnt (0..FIFO_DEPTH) counts in-flight ops plus FIFO entries.
  - +1 on request accept; -1 on rsp handshake; both in the same cycle: unchanged.
  - The FIFO cannot overflow by construction. An assertion fires on a write when full.
- FIFO: first-word-fall-through. rsp_valid = !empty. Data is stable while rsp_valid && !rsp_ready. Simultaneous read and write when full is legal only as read-then-write; it cannot occur with an overfull credit.
- qH config:
  - cfg_qh_we latches cfg_qh into a pending register and sets cfg_busy at the next edge.
  - A write while busy overwrites the pending value (last wins).
  - While cfg_busy, no new grants.
  - When the tag pipeline holds no valid bit and no issue is in progress: mul_qh <= pending, and cfg_busy clears in the same edge. FIFO contents need not drain.
  - cfg_qh_we in the same cycle as an accept: the accept completes under the old qH, then the update waits for drain.
- idle = (credit_cnt==0) && !cfg_busy.

Decomposition:
- Shared package mod_mul_pkg holds: MUL_LAT default, Q_LEN/R constants, and the rsp entry packed struct {id, data}.
- One natural sub-module, sync_fifo_fwft (WIDTH, DEPTH, with count/full/empty outputs). It is reusable elsewhere in the codebase.
- Arbiter, tag pipeline, credit counter and cfg logic stay inline.

Test Plan:
- Bench stub: mul_c = MUL_LAT-deep delay of (mul_a+mul_b) mod 2^Q_LEN.
- Single op: req 2 with a=5, b=7 at cycle 0, rsp_ready=1 -> rsp_valid at cycle 11, rsp_data=12, rsp_id=2; idle=1 after the handshake.
- All 4 requesters valid continuously after reset -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence identical, with no gaps.
- rsp_ready=0, req 1 always valid -> exactly 16 accepts, then req_ready=0. Holding rsp_ready=1 for one cycle -> one rsp and one new accept exactly 1 cycle later.
- cfg_qh_we (qH=0x1234) with 3 ops in flight -> no grants until the third result exits the tag pipe; mul_qh=0x1234 that edge; cfg_busy low; grants resume the next cycle.
- Two cfg writes (0xA then 0xB) while busy -> mul_qh ends 0xB, with one update only.
- rst asserted asynchronously mid-burst with 5 in flight -> all outputs at reset values immediately, no rsp emitted afterwards from stale mul_c, and requester 0 granted first after release.
